sample_ring_buffer: RTL and testbench
=====================================

# sample_ring_buffer

Parametrised on-chip capture memory for the logic analyzer. It sits between `core` (memory write/read strobes) and `uart` (read data back to host), replacing the fixed 32-bit external-SRAM path. It stores samples in a circular buffer of configurable width and depth, with per-byte channel-group masking. On the final write it switches to readout and returns samples newest-first, as the SUMP client expects.

## Interface
Parameters:
- `SDW`, 32, sample width in bits; must be a multiple of 8.
- `DEPTH`, 4096, number of sample entries; any value ≥ 2 (not required to be a power of two).
- `AW`, `$clog2(DEPTH)`, address width (derived).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `cfg_wr`  in  1  load `cfg_groups`; honoured only in IDLE.
- `cfg_groups`  in  SDW/8  channel-group enable mask, one bit per byte lane.
- `arm`  in  1  single-cycle pulse that starts a capture.
- `abort`  in  1  single-cycle pulse: return to IDLE and discard contents.
- `wr_valid`  in  1  sample write strobe (`memoryWrite`).
- `wr_last`  in  1  final sample qualifier (`memoryLastWrite`); meaningful only with `wr_valid`.
- `wr_data`  in  SDW  sample data.
- `rd_ready`  in  1  request for the next readout sample (`memoryRead`).
- `rd_valid`  out  1  `rd_data` valid this cycle.
- `rd_last`  out  1  marks the oldest (final) readout sample.
- `rd_data`  out  SDW  sample; disabled byte lanes read 0.
- `rd_keep`  out  SDW/8  the latched group mask, presented alongside `rd_valid`.
- `busy`  out  1  state ≠ IDLE.
- `full`  out  1  `fill == DEPTH`.
- `fill`  out  AW+1  number of stored samples.

## Operation
- States: IDLE, CAPTURE, READOUT.
- IDLE:
  - `cfg_wr` latches `grp_q <= cfg_groups`.
  - `arm` → CAPTURE, with `wr_ptr = 0` and `fill = 0`.
  - `wr_valid` and `rd_ready` are ignored.
- CAPTURE:
  - Each `wr_valid` writes `wr_data` masked by `grp_q` (disabled lanes stored as 0) to `mem[wr_ptr]`.
  - `wr_ptr` increments; it wraps to 0 after DEPTH-1.
  - `fill` increments and saturates at DEPTH; once saturated, the oldest entries are overwritten.
  - `wr_valid && wr_last` writes the sample, then → READOUT with `rd_ptr` = address just written and `rd_left = fill` (post-update).
  - `arm` while in CAPTURE restarts the capture (pointers and fill cleared).
  - `cfg_wr` is ignored.
- READOUT:
  - `rd_ready` with `rd_left > 0` reads `mem[rd_ptr]`.
  - `rd_ptr` decrements; it wraps from 0 to DEPTH-1.
  - `rd_left` decrements.
  - The request that takes `rd_left` to 0 produces `rd_last` with its data.
  - After `rd_valid && rd_last` → IDLE; `fill` is kept until the next `arm`.
  - `rd_ready` with `rd_left == 0` is ignored.
- `abort` in any state → IDLE with `fill = 0`. Any pending `rd_valid` still fires on the next cycle but `rd_last` is suppressed.
- Same-cycle priority: `abort` > `arm` > `wr_last` > `wr_valid`.
- Memory is a single-port synchronous RAM (inferred). Writes occur only in CAPTURE and reads only in READOUT, so there are never simultaneous read and write.

## Timing
- Reset values: `rd_valid`=0, `rd_last`=0, `rd_data`=0, `rd_keep`=0, `busy`=0, `full`=0, `fill`=0, state IDLE, `grp_q` = all ones.
- Write: `mem` and `fill` update at the edge where `wr_valid` is sampled. `fill` and `full` are registered and visible the next cycle.
- State change: CAPTURE→READOUT takes effect at the edge that samples `wr_last`. `busy` stays 1 across the transition.
- Read latency: `rd_ready` sampled at edge N gives `rd_valid` high for exactly one cycle after edge N+1.
- Throughput: back-to-back `rd_ready` every cycle is supported.
- `rd_data` holds its last value when `rd_valid` = 0.
- `rd_valid`/`rd_last` are single-cycle pulses.
- `rd_keep` equals `grp_q` whenever `rd_valid`=1, and is 0 otherwise.
- Readout delivers exactly `min(writes since arm, DEPTH)` samples.

## Test plan
- DEPTH=8, SDW=32, groups=4'hF: arm, write 0x11..0x15 with `wr_last` on 0x15 → five `rd_ready` pulses yield 0x15,0x14,0x13,0x12,0x11; `rd_last` only on 0x11; sixth `rd_ready` produces no `rd_valid`; `busy` drops after the fifth.
- Wrap: DEPTH=8, write 0x01..0x0B (11 samples, last on 0x0B) → `full`=1, `fill`=8; readout 0x0B down to 0x04; `rd_last` on 0x04.
- Group mask: `cfg_wr` with groups=4'b0101, write 0xAABBCCDD as last → `rd_data`=0x00BB00DD, `rd_keep`=4'b0101.
- `cfg_wr` during CAPTURE (groups=4'b0001) is ignored; mask stays 4'b0101.
- `abort` mid-readout after 2 of 5 reads → next-cycle `rd_valid`=1 with `rd_last`=0, then `busy`=0, `fill`=0; subsequent `rd_ready` ignored.
- Async reset: assert `rst_n`=0 mid-CAPTURE between clock edges → all outputs go to reset values immediately; after release, `wr_valid` without `arm` leaves `fill`=0.

Source files
------------

// File: rtl/sample_ring_buffer.sv
// rtl/sample_ring_buffer.sv - circular capture memory with group masking and newest-first readout
module sample_ring_buffer #(
    parameter int SDW   = 32,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [SDW/8-1:0]   cfg_groups,
    input  logic               arm,
    input  logic               abort,
    input  logic               wr_valid,
    input  logic               wr_last,
    input  logic [SDW-1:0]     wr_data,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic               rd_last,
    output logic [SDW-1:0]     rd_data,
    output logic [SDW/8-1:0]   rd_keep,
    output logic               busy,
    output logic               full,
    output logic [AW:0]        fill
);
    localparam int NG = SDW / 8;
    localparam logic [AW:0]   FILL_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;

    state_t           r_state, w_state_nxt;
    logic [NG-1:0]    r_grp;
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_fill, r_rd_left;
    logic             r_pend, r_pend_last;
    logic             r_rd_valid, r_rd_last;
    logic [SDW-1:0]   r_rd_data, r_ram_q;
    logic [NG-1:0]    r_rd_keep;
    logic [SDW-1:0]   r_mem [DEPTH];

    logic             w_we, w_re;
    logic [SDW-1:0]   w_wmask;
    logic [AW:0]      w_fill_inc;

    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < NG; i++) begin
            w_wmask[8*i +: 8] = {8{r_grp[i]}};
        end
    end

    assign w_we       = (r_state == CAPTURE) && wr_valid && !arm && !abort;
    assign w_re       = (r_state == READOUT) && rd_ready && (r_rd_left != '0) && !abort;
    assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (arm) w_state_nxt = CAPTURE;
            CAPTURE: if (!arm && wr_valid && wr_last) w_state_nxt = READOUT;
            READOUT: if (r_rd_valid && r_rd_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Single-port RAM: write and read enables are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr] <= wr_data & w_wmask;
        if (w_re) r_ram_q <= r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grp       <= '1;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_rd_left   <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
            r_rd_keep   <= '0;
        end else begin
            // Second read stage: RAM output register to the port.
            r_rd_valid  <= r_pend;
            r_rd_last   <= r_pend_last && !abort;
            r_rd_keep   <= r_pend ? r_grp : '0;
            if (r_pend) r_rd_data <= r_ram_q;
            r_pend      <= w_re;
            r_pend_last <= w_re && (r_rd_left == (AW+1)'(1));

            if (abort) begin
                r_fill      <= '0;
                r_rd_left   <= '0;
                r_pend_last <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (cfg_wr) r_grp <= cfg_groups;
                        if (arm) begin
                            r_wr_ptr <= '0;
                            r_fill   <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (arm) begin
                            r_wr_ptr <= '0;
                            r_fill   <= '0;
                        end else if (wr_valid) begin
                            r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
                            r_fill   <= w_fill_inc;
                            if (wr_last) begin
                                r_rd_ptr  <= r_wr_ptr;
                                r_rd_left <= w_fill_inc;
                            end
                        end
                    end
                    READOUT: begin
                        if (w_re) begin
                            r_rd_ptr  <= (r_rd_ptr == '0) ? LAST_ADDR : r_rd_ptr - 1'b1;
                            r_rd_left <= r_rd_left - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign rd_data  = r_rd_data;
    assign rd_keep  = r_rd_keep;
    assign busy     = (r_state != IDLE);
    assign full     = (r_fill == FILL_MAX);
    assign fill     = r_fill;
endmodule

// File: tb/tb_sample_ring_buffer.sv
// tb/tb_sample_ring_buffer.sv - directed self-checking bench for sample_ring_buffer
module tb_sample_ring_buffer;
    localparam int SDW   = 32;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [3:0]       cfg_groups = 4'hF;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_last = 1'b0;
    logic [SDW-1:0]   wr_data = '0;
    logic             rd_ready = 1'b0;
    logic             rd_valid, rd_last, busy, full;
    logic [SDW-1:0]   rd_data;
    logic [3:0]       rd_keep;
    logic [AW:0]      fill;

    int n_chk  = 0;
    int n_pass = 0;

    sample_ring_buffer #(.SDW(SDW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_groups(cfg_groups),
        .arm(arm), .abort(abort), .wr_valid(wr_valid), .wr_last(wr_last),
        .wr_data(wr_data), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_last(rd_last), .rd_data(rd_data), .rd_keep(rd_keep),
        .busy(busy), .full(full), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic do_cfg(input logic [3:0] g);
        cfg_wr = 1'b1;
        cfg_groups = g;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic do_write(input logic [SDW-1:0] d, input logic last);
        wr_valid = 1'b1;
        wr_last  = last;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic read_one(input string tag, input logic [SDW-1:0] exp_d,
                            input logic exp_last, input logic [3:0] exp_keep);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk({tag, "_lat"}, rd_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_vld"}, rd_valid, 1'b1);
        chk({tag, "_dat"}, rd_data, exp_d);
        chk({tag, "_lst"}, rd_last, exp_last);
        chk({tag, "_kep"}, rd_keep, exp_keep);
    endtask

    initial begin
        #12;
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_last", rd_last, 1'b0);
        chk("rst_data", rd_data, 32'h0);
        chk("rst_keep", rd_keep, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_fill", fill, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic capture of five samples, newest-first readout.
        do_arm();
        chk("t1_busy", busy, 1'b1);
        chk("t1_fill0", fill, 4'd0);
        for (int i = 0; i < 5; i++) do_write(32'h11 + i, i == 4);
        chk("t1_fill", fill, 4'd5);
        chk("t1_full", full, 1'b0);
        chk("t1_busy_ro", busy, 1'b1);
        for (int i = 0; i < 5; i++) read_one("t1_rd", 32'h15 - i, i == 4, 4'hF);
        @(negedge clk);
        chk("t1_pulse", rd_valid, 1'b0);
        chk("t1_idle", busy, 1'b0);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("t1_rd6a", rd_valid, 1'b0);
        @(negedge clk);
        chk("t1_rd6b", rd_valid, 1'b0);
        chk("t1_fill_kept", fill, 4'd5);

        // Wrap with back-to-back readout.
        do_arm();
        for (int i = 1; i <= 11; i++) do_write(i, i == 11);
        chk("t2_fill", fill, 4'd8);
        chk("t2_full", full, 1'b1);
        rd_ready = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            if (k == 7) rd_ready = 1'b0;
            if (k == 0 || k == 9) begin
                chk("t2_novld", rd_valid, 1'b0);
            end else begin
                chk("t2_vld", rd_valid, 1'b1);
                chk("t2_dat", rd_data, 32'hC - k);
                chk("t2_lst", rd_last, k == 8);
            end
        end
        chk("t2_idle", busy, 1'b0);

        // Group mask, and cfg_wr ignored during capture.
        do_cfg(4'b0101);
        do_arm();
        do_cfg(4'b0001);
        do_write(32'hAABBCCDD, 1'b1);
        chk("t3_fill", fill, 4'd1);
        read_one("t3_rd", 32'h00BB00DD, 1'b1, 4'b0101);
        @(negedge clk);
        chk("t3_idle", busy, 1'b0);
        do_cfg(4'hF);

        // Abort mid-readout after two of five reads.
        do_arm();
        for (int i = 0; i < 5; i++) do_write(32'h21 + i, i == 4);
        rd_ready = 1'b1;
        @(negedge clk);
        chk("t4_lat", rd_valid, 1'b0);
        @(negedge clk);
        chk("t4_v1", rd_valid, 1'b1);
        chk("t4_d1", rd_data, 32'h25);
        rd_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_v2", rd_valid, 1'b1);
        chk("t4_d2", rd_data, 32'h24);
        chk("t4_l2", rd_last, 1'b0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_fill", fill, 4'd0);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        chk("t4_ign1", rd_valid, 1'b0);
        @(negedge clk);
        chk("t4_ign2", rd_valid, 1'b0);

        // Asynchronous reset mid-capture, then verify reset mask and idle behaviour.
        do_cfg(4'b0101);
        do_arm();
        do_write(32'h1, 1'b0);
        do_write(32'h2, 1'b0);
        chk("t5_fill_pre", fill, 4'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 1'b0);
        chk("t5_fill", fill, 4'd0);
        chk("t5_keep", rd_keep, 4'h0);
        chk("t5_data", rd_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(32'h3, 1'b0);
        do_write(32'h4, 1'b1);
        chk("t5_nofill", fill, 4'd0);
        chk("t5_nobusy", busy, 1'b0);
        do_arm();
        do_write(32'hAABBCCDD, 1'b1);
        read_one("t5_rd", 32'hAABBCCDD, 1'b1, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
